// File: rtl/instr_encoder_stream.sv
// ============================================================================
// instr_encoder_stream
// ----------------------------------------------------------------------------
// Packs RISC-V RV32I instruction fields into 32-bit instruction words. It is
// the inverse of the instruction-field decoder. Field sets arrive on a
// valid/ready stream. Each packed word leaves through a single registered
// valid/ready stage and carries a sequential instruction-memory byte address.
// Consumers are the instruction-memory loader and the self-test program
// generator.
//
// Parameters:
//   BASE_ADDR  byte address given to the first word after reset or clear
//   DEPTH      number of words accepted before the block reports full (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous restart: index to 0, drop pending word, leave FULL
//   in_valid   a field set is present
//   in_ready   the field set is taken when in_valid && in_ready
//   in_fmt     0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal
//   in_opcode  opcode field
//   in_funct3  funct3 field
//   in_funct7  funct7 field (R format only)
//   in_rd      destination register
//   in_rs1     source register 1
//   in_rs2     source register 2
//   in_imm     immediate as a full signed byte value (U: upper 20 bits)
//   out_valid  an encoded word is present
//   out_ready  the consumer takes the word when out_valid && out_ready
//   out_word   encoded instruction word
//   out_addr   BASE_ADDR + 4*index, captured when the word was accepted
//   out_err    the field set was out of range or the format was illegal
//   full       DEPTH words were accepted since the last reset or clear
// ============================================================================
module instr_encoder_stream #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        full
);

    // Format codes carried on in_fmt.
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // addi x0, x0, 0. This word is emitted for an illegal format code.
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // The word accepted at this index is the DEPTH-th one.
    localparam logic [31:0] LAST_INDEX = 32'(DEPTH - 1);

    typedef enum logic {
        ST_LOAD,
        ST_FULL
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] index;
    logic        accept;
    logic [31:0] packed_word;
    logic        packed_err;

    assign accept = in_valid && in_ready;

    // Packing and range checking. The checks only raise out_err. The word is
    // always packed from the truncated fields, so that the error path and the
    // normal path share one mux.
    always_comb begin
        packed_word = NOP_WORD;
        packed_err  = 1'b1;
        case (in_fmt)
            FMT_R: begin
                packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                packed_err  = 1'b0;
            end
            FMT_I: begin
                packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                packed_err  = (in_imm != {{20{in_imm[11]}}, in_imm[11:0]});
            end
            FMT_S: begin
                packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:0], in_opcode};
                packed_err  = (in_imm != {{20{in_imm[11]}}, in_imm[11:0]});
            end
            FMT_B: begin
                // Branch offsets are halfword-aligned, so an odd offset
                // cannot be encoded.
                packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
                packed_err  = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
            end
            FMT_U: begin
                packed_word = {in_imm[31:12], in_rd, in_opcode};
                packed_err  = (in_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                packed_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, in_opcode};
                packed_err  = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
            end
            default: begin
                packed_word = NOP_WORD;
                packed_err  = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The block enters FULL on the edge that accepts the
    // DEPTH-th word. Only clear (or reset) brings it back to LOAD.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_LOAD;
        end else if ((state == ST_LOAD) && accept && (index == LAST_INDEX)) begin
            state_next = ST_FULL;
        end
    end

    // Outputs decoded from the state. The single output register may take a
    // new word on the same edge the old one leaves, so a continuous stream
    // runs without bubbles.
    always_comb begin
        in_ready = (state == ST_LOAD) && !clear && (!out_valid || out_ready);
        full     = (state == ST_FULL);
    end

    // Output register and address index. The address is captured at
    // acceptance from the index at that time. A stalled word therefore keeps
    // its address even though the index already points past it. Clear
    // discards a pending word outright. The consumer never sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            out_addr  <= BASE_ADDR;
            out_err   <= 1'b0;
            index     <= 32'd0;
        end else if (clear) begin
            out_valid <= 1'b0;
            index     <= 32'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_word  <= packed_word;
            out_err   <= packed_err;
            out_addr  <= BASE_ADDR + (index << 2);
            index     <= index + 32'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder_stream.sv
// ============================================================================
// tb_instr_encoder_stream
// ----------------------------------------------------------------------------
// Directed bench for instr_encoder_stream. The base address is placed just
// below 2^32 so that the address wraps. DEPTH is small so that the full
// boundary is reached quickly. When a field set is accepted, the stimulus
// pushes its hand-computed encoding onto a queue. An independent monitor pops
// the queue on every output transfer and compares.
// ============================================================================
module tb_instr_encoder_stream;

    localparam logic [31:0] TB_BASE  = 32'hFFFF_FFF8;
    localparam int          TB_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        out_err;
    logic        full;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   idx      = 0;
    int   sb_count = 0;
    int   w;

    instr_encoder_stream #(
        .BASE_ADDR (TB_BASE),
        .DEPTH     (TB_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .full      (full)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stops the run if the sequence stalls somewhere unexpected.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one value against its expected value and records the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor. A transfer happens at the next rising edge whenever
    // out_valid && out_ready holds mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got word=%h addr=%h err=%b, expected no word",
                         out_word, out_addr, out_err);
            end else begin
                e = exp_q.pop_front();
                checks++;
                sb_count++;
                if (out_word !== e.word || out_addr !== e.addr || out_err !== e.err) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_%0d: got word=%h addr=%h err=%b, expected word=%h addr=%h err=%b",
                             sb_count, out_word, out_addr, out_err, e.word, e.addr, e.err);
                end
            end
        end
    end

    // Drives one field set and waits (bounded) until it is accepted. Call
    // this task just after a rising edge. It returns just after the edge
    // that accepted the field set.
    task automatic applyStimulus(input string name, input logic [2:0] fmt,
                                 input logic [6:0] opcode, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] exp_word,
                                 input logic exp_err, output int waits);
        exp_t e;
        in_fmt    = fmt;
        in_opcode = opcode;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
        waits     = 0;
        @(negedge clk);
        while (!in_ready && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        e.word = exp_word;
        e.addr = TB_BASE + (32'(idx) << 2);
        e.err  = exp_err;
        exp_q.push_back(e);
        idx++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) until every expected word has left the DUT.
    task automatic waitDrain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_drained"}, 32'((exp_q.size() == 0) && !out_valid), 32'd1);
    endtask

    // Pulses clear for one cycle and checks the restart.
    task automatic doClear(input string name);
        clear = 1'b1;
        #1;
        checkOutput({name, "_clr_in_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        idx = 0;
        checkOutput({name, "_clr_full"}, 32'(full), 32'd0);
        checkOutput({name, "_clr_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_fmt    = 3'd0;
        in_opcode = 7'd0;
        in_funct3 = 3'd0;
        in_funct7 = 7'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_imm    = 32'd0;
        #1 rst_n  = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_word", out_word, 32'd0);
        checkOutput("rst_addr", out_addr, TB_BASE);
        checkOutput("rst_err", 32'(out_err), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: R-type add x3,x1,x2 with one-cycle latency
        $display("[TB] test 1: R-type");
        applyStimulus("t1_add", 3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,
                      32'h002081B3, 1'b0, w);
        checkOutput("t1_latency_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_latency_word", out_word, 32'h002081B3);
        waitDrain("t1");
        doClear("t1");

        // 2: back-to-back I then U
        $display("[TB] test 2: back-to-back I/U");
        applyStimulus("t2_addi", 3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF,
                      32'hFFF00293, 1'b0, w);
        applyStimulus("t2_lui", 3'd4, 7'h37, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000,
                      32'h12345537, 1'b0, w);
        checkOutput("t2_b2b_waits", 32'(w), 32'd0);
        waitDrain("t2");

        // 3: B/J encodings; the address wraps past 2^32, and the 4th word fills
        $display("[TB] test 3: B/J and error cases");
        applyStimulus("t3_beq", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,
                      32'hFE208EE3, 1'b0, w);
        applyStimulus("t3_jal", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800,
                      32'h001000EF, 1'b0, w);
        checkOutput("t3_full", 32'(full), 32'd1);
        checkOutput("t3_full_in_ready", 32'(in_ready), 32'd0);
        waitDrain("t3a");
        doClear("t3");
        applyStimulus("t3_b_odd", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0003,
                      32'h00000163, 1'b1, w);
        applyStimulus("t3_u_low", 3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0001,
                      32'h00000037, 1'b1, w);
        waitDrain("t3b");

        // 4: backpressure holds the output and the index
        $display("[TB] test 4: backpressure");
        out_ready = 1'b0;
        applyStimulus("t4_add", 3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,
                      32'h003100B3, 1'b0, w);
        in_fmt    = 3'd0;
        in_opcode = 7'h33;
        in_funct7 = 7'h20;
        in_rd     = 5'd5;
        in_rs1    = 5'd6;
        in_rs2    = 5'd7;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t4_stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("t4_stall_word", out_word, 32'h003100B3);
            checkOutput("t4_stall_addr", out_addr, 32'h0000_0000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus("t4_sub", 3'd0, 7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'd0,
                      32'h407302B3, 1'b0, w);
        checkOutput("t4_release_waits", 32'(w), 32'd0);
        checkOutput("t4_full", 32'(full), 32'd1);
        waitDrain("t4");
        doClear("t4");

        // 5: six requests against DEPTH=4, then clear restarts at the base
        $display("[TB] test 5: depth boundary");
        applyStimulus("t5_sw", 3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'h0000_0008,
                      32'h0020A423, 1'b0, w);
        applyStimulus("t5_sw_neg", 3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,
                      32'hFE20AE23, 1'b0, w);
        applyStimulus("t5_i_range", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800,
                      32'h80000093, 1'b1, w);
        checkOutput("t5_not_full_at_3", 32'(full), 32'd0);
        applyStimulus("t5_j_range", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000,
                      32'h8000006F, 1'b1, w);
        checkOutput("t5_full_at_4", 32'(full), 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("t5_extra_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        waitDrain("t5a");
        doClear("t5");
        applyStimulus("t5_restart", 3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,
                      32'h002081B3, 1'b0, w);
        waitDrain("t5b");
        doClear("t5b");

        // 6: async reset drops a pending word; illegal formats give a NOP
        $display("[TB] test 6: reset mid-stream");
        out_ready = 1'b0;
        applyStimulus("t6_pending", 3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,
                      32'h00000013, 1'b1, w);
        checkOutput("t6_pending_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_async_addr", out_addr, TB_BASE);
        checkOutput("t6_async_err", 32'(out_err), 32'd0);
        exp_q.delete();
        idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus("t6_fmt7", 3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,
                      32'h00000013, 1'b1, w);
        applyStimulus("t6_fmt6", 3'd6, 7'h6F, 3'd1, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF,
                      32'h00000013, 1'b1, w);
        waitDrain("t6");

        checkOutput("scoreboard_left", 32'(exp_q.size()), 32'd0);
        checkOutput("scoreboard_count", 32'(sb_count), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_stream.md
Name: instr_encoder_stream

Overview:
Inverse of the instruction-field decoder. It accepts RISC-V RV32I instruction fields plus a format code on a valid/ready input stream and packs them into 32-bit instruction words. Each word goes out on a registered valid/ready stream, tagged with a sequential instruction-memory byte address. The block feeds the instruction-memory loader and the self-test program generator.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first emitted word
DEPTH, 1024, words emitted before the block reports full (must be ≥1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous restart: index to 0, drop pending word, leave FULL
in_valid  input  1  field set present
in_ready  output  1  field set accepted when in_valid && in_ready
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6–7 illegal
in_opcode  input  7  opcode field
in_funct3  input  3  funct3 field
in_funct7  input  7  funct7 field (R only)
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  immediate as a full signed byte value (U: upper 20 bits significant)
out_valid  output  1  encoded word present
out_ready  input  1  consumer accepts when out_valid && out_ready
out_word  output  32  encoded instruction
out_addr  output  32  BASE_ADDR + 4*index
out_err  output  1  field set was out of range or illegal
full  output  1  DEPTH words accepted since reset/clear

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_word=0, out_addr=BASE_ADDR, out_err=0, full=0, index=0, state=LOAD.
- States:
  - LOAD: normal operation.
  - FULL: entered when the accepted-word count reaches DEPTH. In FULL, in_ready=0.
  - Only clear or reset leaves FULL.
- in_ready = (state==LOAD) && !clear && (!out_valid || out_ready). Pass-through single-register stage, no bubble under continuous flow.
- Latency: a word accepted at edge N appears on out_* at edge N (registered), valid from cycle N+1.
- out_* stay stable while out_valid && !out_ready.
- Address and index:
  - out_addr = BASE_ADDR + 4*index, captured at acceptance.
  - index increments on every accepted input, including error words.
  - out_addr wraps modulo 2^32.
- Packing, by format:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- out_err=1 in these cases; the word is still packed from the truncated fields:
  - I/S: imm not the sign-extension of imm[11:0].
  - B: imm not the sign-extension of imm[12:0], or imm[0]=1.
  - J: imm not the sign-extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0]≠0.
- Illegal fmt (6, 7): out_word=32'h0000_0013 (NOP), out_err=1.
- Transition to FULL: when the DEPTH-th word is accepted, state goes to FULL on the same edge. That word still drains normally. full = (state==FULL).
- clear (synchronous, priority over input):
  - index=0, state=LOAD, out_valid=0; any pending word is discarded.
  - No input is accepted in the clear cycle.
- Simultaneous out transfer and in transfer in one cycle: the new word replaces the old one with no gap.
- Reset mid-stream: the pending word is discarded immediately (async); after reset is released, addresses restart at BASE_ADDR.

Test Plan:
1. R, opcode 0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, out_ready=1 -> out_word 32'h002081B3, addr BASE, err 0, one-cycle latency.
2. I addi x5,x0,-1 (opcode 0x13, imm=-1), then U lui x10 (opcode 0x37, imm 32'h12345000) back-to-back -> 32'hFFF00293 @BASE, 32'h12345537 @BASE+4, in_ready held high.
3. B beq x1,x2,imm=-4 (opcode 0x63) -> 32'hFE208EE3. J jal x1,imm=2048 (opcode 0x6F) -> 32'h001000EF. B with imm=3 -> err=1. U with imm=32'h1 -> err=1.
4. Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_word/out_addr constant, in_ready=0, no index advance. Release -> next word at +4.
5. DEPTH=4: stream 6 requests -> exactly 4 accepted, full=1 and in_ready=0 after the 4th. Pulse clear -> full=0, next word at BASE_ADDR.
6. Assert rst_n low with out_valid=1 and fmt=7 pending -> out_valid=0 immediately. After release, a fmt=7 request -> NOP 32'h00000013, err=1, addr BASE.
